cpu_seq_ctrl: RTL and testbench

- Instruction sequencer (control unit) for the 8-bit accumulator CPU.
- Latches the opcode fetched from the data input bus and steps the fetch/execute/memory-read phases.
- Drives the strobes that move data in the datapath: PC increment/load, instruction latch, operand/MAR latch, address-mux select, and A-register load with source select.
- Sits between the PC/MAR/A-register datapath and the external data bus.

---
 rtl/cpu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Instruction sequencer for the 8-bit accumulator CPU. It latches the opcode
// from the data bus during FETCH, then steps EXEC (and MEM for loads),
// producing the strobes that move data through the PC / MAR / A datapath.
//
// Ports:
//   clk         in   system clock, rising-edge active
//   reset       in   asynchronous, active-high reset
//   data_in     in   data bus: opcode/operand byte for the current cycle
//   stall       in   freeze request (see stall semantics below)
//   addr_sel    out  address mux select: 0 = PC, 1 = MAR
//   pc_inc      out  PC <= PC + 1 at the closing edge
//   pc_load     out  PC <= data_in at the closing edge
//   ir_load     out  instruction register <= data_in
//   mar_load    out  MAR <= data_in
//   a_load      out  A <= selected source
//   a_src       out  A source: 0 = A + data_in (mod 256), 1 = data_in
//   instr_done  out  last cycle of the current instruction
//   illegal_op  out  one-cycle pulse on an undefined opcode
//   halted      out  controller is in HALT
//   state_dbg   out  state encoding: FETCH=0, EXEC=1, MEM=2, HALT=3
//
// Stall semantics: stall is a level request sampled at every rising edge.
// While stall=1 the state and the opcode latch hold, and every strobe
// (pc_inc, pc_load, ir_load, mar_load, a_load, instr_done, illegal_op) is
// forced low in that cycle. addr_sel, a_src and state_dbg keep their normal
// decode so the address bus does not move. Dropping stall resumes the same
// state, so each strobe is issued exactly once per instruction.
//
// All outputs are a combinational decode of the state, the latched opcode,
// stall and reset; none depends combinationally on data_in.
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   OPC_NOP = 8'h00,
    parameter logic [DW-1:0]   OPC_ADD = 8'h01,
    parameter logic [DW-1:0]   OPC_LOD = 8'h02,
    parameter logic [DW-1:0]   OPC_JMP = 8'h03,
    parameter logic [DW-1:0]   OPC_HLT = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          stall,
    output logic          addr_sel,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          ir_load,
    output logic          mar_load,
    output logic          a_load,
    output logic          a_src,
    output logic          instr_done,
    output logic          illegal_op,
    output logic          halted,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] opcode;

    // Ungated strobe decode, before stall/reset suppression.
    logic raw_pc_inc;
    logic raw_pc_load;
    logic raw_ir_load;
    logic raw_mar_load;
    logic raw_a_load;
    logic raw_instr_done;
    logic raw_illegal_op;
    logic strobe_en;

    // -------------------------------------------------------------------------
    // State and opcode latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            opcode <= '0;
        end else if (!stall) begin
            case (state)
                S_FETCH: begin
                    opcode <= data_in;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == OPC_LOD) begin
                        state <= S_MEM;
                    end else if (opcode == OPC_HLT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM:   state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        raw_pc_inc     = 1'b0;
        raw_pc_load    = 1'b0;
        raw_ir_load    = 1'b0;
        raw_mar_load   = 1'b0;
        raw_a_load     = 1'b0;
        raw_instr_done = 1'b0;
        raw_illegal_op = 1'b0;
        addr_sel       = 1'b0;
        a_src          = 1'b0;

        case (state)
            S_FETCH: begin
                raw_ir_load = 1'b1;
                raw_pc_inc  = 1'b1;
            end
            S_EXEC: begin
                // ADD and LOD step the PC past their operand byte while it
                // is on the bus; JMP loads the operand into the PC instead.
                if (opcode == OPC_NOP) begin
                    raw_instr_done = 1'b1;
                end else if (opcode == OPC_ADD) begin
                    raw_pc_inc     = 1'b1;
                    raw_a_load     = 1'b1;
                    raw_instr_done = 1'b1;
                end else if (opcode == OPC_LOD) begin
                    raw_pc_inc     = 1'b1;
                    raw_mar_load   = 1'b1;
                end else if (opcode == OPC_JMP) begin
                    raw_pc_load    = 1'b1;
                    raw_instr_done = 1'b1;
                end else if (opcode == OPC_HLT) begin
                    raw_instr_done = 1'b1;
                end else begin
                    raw_illegal_op = 1'b1;
                    raw_instr_done = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel       = 1'b1;
                a_src          = 1'b1;
                raw_a_load     = 1'b1;
                raw_instr_done = 1'b1;
            end
            default: begin
                // HALT: everything idle.
            end
        endcase
    end

    // Reset is included so that FETCH's decode cannot leak strobes while the
    // controller is being held in reset.
    assign strobe_en  = !stall && !reset;

    assign pc_inc     = raw_pc_inc     && strobe_en;
    assign pc_load    = raw_pc_load    && strobe_en;
    assign ir_load    = raw_ir_load    && strobe_en;
    assign mar_load   = raw_mar_load   && strobe_en;
    assign a_load     = raw_a_load     && strobe_en;
    assign instr_done = raw_instr_done && strobe_en;
    assign illegal_op = raw_illegal_op && strobe_en;

    assign halted     = (state == S_HALT);
    assign state_dbg  = state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq_ctrl
//
// Bench for cpu_seq_ctrl. A small datapath (PC, MAR, A, 256-byte memory) is
// attached to the controller's strobes. An instruction-level model of the
// accumulator ISA predicts PC and A after each instruction; a per-cycle
// table derived from the instruction timing predicts the strobe vector.
// -----------------------------------------------------------------------------
module tb_cpu_seq_ctrl;

  localparam logic [7:0] OPC_NOP = 8'h00;
  localparam logic [7:0] OPC_ADD = 8'h01;
  localparam logic [7:0] OPC_LOD = 8'h02;
  localparam logic [7:0] OPC_JMP = 8'h03;
  localparam logic [7:0] OPC_HLT = 8'hFF;

  // Vector bit order:
  // {addr_sel, pc_inc, pc_load, ir_load, mar_load, a_load, a_src,
  //  instr_done, illegal_op, halted}
  localparam logic [9:0] STROBE_MASK = 10'b0111110110;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       stall = 1'b0;
  logic       addr_sel, pc_inc, pc_load, ir_load, mar_load;
  logic       a_load, a_src, instr_done, illegal_op, halted;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .stall      (stall),
    .addr_sel   (addr_sel),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .ir_load    (ir_load),
    .mar_load   (mar_load),
    .a_load     (a_load),
    .a_src      (a_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Bench datapath and models
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [256];
  logic [7:0]  pc, mar, a;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Cycle model: position inside the current instruction (0 = fetch cycle,
  // 1 = first execute cycle, 2 = memory cycle of a load).
  int          cyc;
  logic [7:0]  m_op;
  bit          m_halt;
  int          stall_mode;   // 0 none, 1 random, 2 three cycles in each MEM
  int          mem_stalls;

  // ISA model state and expected {pc, a} per completed instruction.
  logic [7:0]  ipc, ia;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_vec(input logic [7:0] op, input int c,
                                         input bit h);
    logic [9:0] v;
    v = 10'b0;
    if (h) begin
      v[0] = 1'b1;
    end else if (c == 0) begin
      v[8] = 1'b1; v[6] = 1'b1;
    end else if (c == 2) begin
      v[9] = 1'b1; v[4] = 1'b1; v[3] = 1'b1; v[2] = 1'b1;
    end else begin
      case (op)
        OPC_NOP: v[2] = 1'b1;
        OPC_ADD: begin v[8] = 1'b1; v[4] = 1'b1; v[2] = 1'b1; end
        OPC_LOD: begin v[8] = 1'b1; v[5] = 1'b1; end
        OPC_JMP: begin v[7] = 1'b1; v[2] = 1'b1; end
        OPC_HLT: v[2] = 1'b1;
        default: begin v[1] = 1'b1; v[2] = 1'b1; end
      endcase
    end
    return v;
  endfunction

  // Architectural effect of one complete instruction.
  task automatic isa_exec();
    logic [7:0] nxt, imm;
    nxt = ipc + 8'd1;
    imm = mem[nxt];
    case (m_op)
      OPC_NOP: ipc = nxt;
      OPC_ADD: begin ia = ia + imm; ipc = nxt + 8'd1; end
      OPC_LOD: begin ia = mem[imm]; ipc = nxt + 8'd1; end
      OPC_JMP: ipc = imm;
      OPC_HLT: begin ipc = nxt; m_halt = 1'b1; end
      default: ipc = nxt;
    endcase
    exp_q.push_back({ipc, ia});
  endtask

  task automatic model_reset();
    pc = 8'h00; mar = 8'h00; a = 8'h00;
    ipc = 8'h00; ia = 8'h00;
    cyc = 0; m_op = 8'h00; m_halt = 1'b0; mem_stalls = 0;
    exp_q.delete();
  endtask

  function automatic logic [9:0] obs_vec();
    return {addr_sel, pc_inc, pc_load, ir_load, mar_load, a_load, a_src,
            instr_done, illegal_op, halted};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    data_in = 8'h00;
    @(negedge clk);
    #1;
    check("reset_vec", {22'b0, obs_vec()}, 32'h0);
    check("reset_state", {30'b0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check, advance the models, update the datapath.
  task automatic step();
    bit         st, done;
    logic [9:0] ev;
    logic [9:0] ov;
    logic [15:0] e;
    @(negedge clk);
    case (stall_mode)
      1:       st = ($urandom_range(0, 3) == 0);
      2:       st = (cyc == 2) && (mem_stalls < 3);
      default: st = 1'b0;
    endcase
    if (st && cyc == 2) mem_stalls++;
    stall = st;
    data_in = addr_sel ? mem[mar] : mem[pc];
    #1;
    ov = obs_vec();
    ev = exp_vec(m_op, cyc, m_halt);
    if (st) ev = ev & ~STROBE_MASK;
    check("strobes", {22'b0, ov}, {22'b0, ev});
    check("state_dbg", {30'b0, state_dbg}, m_halt ? 32'd3 : cyc);

    done = 1'b0;
    if (!st && !m_halt) begin
      if (cyc == 0) begin
        m_op = mem[ipc];
        cyc = 1;
      end else if (cyc == 1 && m_op == OPC_LOD) begin
        cyc = 2;
      end else begin
        isa_exec();
        cyc = 0;
        mem_stalls = 0;
        done = 1'b1;
      end
    end

    @(posedge clk);
    if (ov[7])      pc = data_in;
    else if (ov[8]) pc = pc + 8'd1;
    if (ov[5]) mar = data_in;
    if (ov[4]) a = ov[3] ? data_in : a + data_in;

    if (done) begin
      e = exp_q.pop_front();
      check("pc_after_instr", {24'b0, pc}, {24'b0, e[15:8]});
      check("a_after_instr", {24'b0, a}, {24'b0, e[7:0]});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int budget;
    int r;

    // Directed program: 00 | 01 02 | 02 2A | 01 05 | 01 C0 | 03 10
    // then at 0x10: 7E | 02 2A (stalled in MEM) | FF, with mem[0x2A]=0x45.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h00;
    mem[8'h01] = 8'h01; mem[8'h02] = 8'h02;
    mem[8'h03] = 8'h02; mem[8'h04] = 8'h2A;
    mem[8'h05] = 8'h01; mem[8'h06] = 8'h05;
    mem[8'h07] = 8'h01; mem[8'h08] = 8'hC0;
    mem[8'h09] = 8'h03; mem[8'h0A] = 8'h10;
    mem[8'h10] = 8'h7E;
    mem[8'h11] = 8'h02; mem[8'h12] = 8'h2A;
    mem[8'h13] = 8'hFF;
    mem[8'h2A] = 8'h45;

    do_reset();
    stall_mode = 2;
    budget = 0;
    while (!m_halt && budget < 200) begin
      step();
      budget++;
    end
    check("directed_halt_reached", {31'b0, m_halt}, 32'd1);
    check("directed_final_a", {24'b0, a}, 32'h45);
    check("directed_final_pc", {24'b0, pc}, 32'h14);

    // Ten cycles parked in HALT with stall toggling.
    stall_mode = 1;
    for (int i = 0; i < 10; i++) step();
    check("halt_flag", {31'b0, halted}, 32'd1);

    // Reset arriving asynchronously in the EXEC cycle of an ADD.
    mem[8'h00] = OPC_ADD; mem[8'h01] = 8'h33;
    do_reset();
    stall_mode = 0;
    step();
    @(negedge clk);
    stall = 1'b0;
    data_in = mem[pc];
    #1;
    check("add_exec_a_load", {31'b0, a_load}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_vec", {22'b0, obs_vec()}, 32'h0);
    check("midreset_state", {30'b0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step();

    // Random programs with random stalls.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 59);
        if (r == 0)       mem[i] = OPC_HLT;
        else if (r < 10)  mem[i] = OPC_NOP;
        else if (r < 22)  mem[i] = OPC_ADD;
        else if (r < 34)  mem[i] = OPC_LOD;
        else if (r < 40)  mem[i] = OPC_JMP;
        else              mem[i] = 8'($urandom_range(0, 255));
      end
      do_reset();
      stall_mode = 1;
      for (int i = 0; i < 400; i++) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
